// File: rtl/conv_window_feeder_if.sv
`default_nettype none
// ============================================================================
// Module  : conv_window_feeder_if
// Brief   : Load port, pass control and tap stream of conv_window_feeder.
// Rev     : 1.0
// ============================================================================
interface conv_window_feeder_if;
  logic               wr_en;
  logic [1:0]         wr_sel;
  logic [9:0]         wr_addr;
  logic signed [15:0] wr_data;
  logic               go;
  logic               conv_ready;
  logic signed [15:0] pixel_out;
  logic signed [15:0] weight_out [3:1];
  logic               start;
  logic               ready_in;
  logic [7:0]         win_row;
  logic [7:0]         win_col;
  logic               busy;
  logic               done;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, go, conv_ready,
    input  pixel_out, weight_out, start, ready_in, win_row, win_col, busy, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, go, conv_ready,
    output pixel_out, weight_out, start, ready_in, win_row, win_col, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/conv_window_feeder.sv
`default_nettype none
// ============================================================================
// Module  : conv_window_feeder
// Brief   : Streams every KxK window of a square image, tap by tap, with the
//           matching per-channel kernel weights one cycle ahead.
// Rev     : 1.0
// ============================================================================
module conv_window_feeder #(
  parameter int IMG_W = 28,
  parameter int K     = 5,
  parameter int NCH   = 3
) (
  input  logic               clk,
  input  logic               n_reset,
  conv_window_feeder_if.slave bus
);
  localparam int c_NT = K * K;
  localparam int c_AW = 10;
  localparam int c_KW = (c_NT > 1) ? $clog2(c_NT) : 1;
  localparam int c_RW = (K > 1) ? $clog2(K) : 1;

  localparam logic [c_KW-1:0] c_TLAST = c_KW'(c_NT - 1);
  localparam logic [c_KW-1:0] c_TPEN  = c_KW'(c_NT - 2);
  localparam logic [c_RW-1:0] c_KLAST = c_RW'(K - 1);
  localparam logic [7:0]      c_WLAST = 8'(IMG_W - K);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_PRIME  = 3'd1;
  localparam logic [2:0] c_STREAM = 3'd2;
  localparam logic [2:0] c_WAIT   = 3'd3;
  localparam logic [2:0] c_DONE   = 3'd4;

  logic [2:0]         r_state;
  logic [c_KW-1:0]    r_tap;
  logic [c_RW-1:0]    r_kr;
  logic [c_RW-1:0]    r_kc;
  logic [7:0]         r_row;
  logic [7:0]         r_col;
  logic signed [15:0] r_pixel;
  logic signed [15:0] r_img [2**c_AW];

  logic               w_wr_ok;
  logic               w_last_tap;
  logic               w_last_win;
  logic [c_RW-1:0]    w_nkr;
  logic [c_RW-1:0]    w_nkc;
  logic [c_RW-1:0]    w_row_off;
  logic [c_RW-1:0]    w_col_off;
  logic [c_AW-1:0]    w_pix_addr;
  logic               w_pix_zero;
  logic [c_KW-1:0]    w_k_idx;
  logic               w_k_zero;

  assign w_wr_ok    = bus.wr_en && (r_state == c_IDLE);
  assign w_last_tap = (r_tap == c_TLAST);
  assign w_last_win = (r_row == c_WLAST) && (r_col == c_WLAST);

  // Kernel-relative position of the tap after the current one.
  always_comb begin
    w_nkr = r_kr;
    w_nkc = r_kc + 1'b1;
    if (r_kc == c_KLAST) begin
      w_nkc = '0;
      w_nkr = r_kr + 1'b1;
    end
  end

  // Read addresses are for the value needed in the *next* cycle, so the
  // registered memory outputs line up with the state being entered.
  always_comb begin
    w_pix_zero = 1'b1;
    w_k_zero   = 1'b1;
    w_k_idx    = '0;
    w_row_off  = '0;
    w_col_off  = '0;
    case (r_state)
      c_IDLE:  w_k_zero = !bus.go;
      c_PRIME: begin
        w_pix_zero = 1'b0;
        w_k_idx    = c_KW'(1);
        w_k_zero   = (c_NT < 2);
      end
      c_STREAM: begin
        if (!w_last_tap) begin
          w_pix_zero = 1'b0;
          w_row_off  = w_nkr;
          w_col_off  = w_nkc;
          w_k_idx    = r_tap + c_KW'(2);
          w_k_zero   = (r_tap == c_TPEN);
        end
      end
      c_WAIT:  w_k_zero = !(bus.conv_ready && !w_last_win);
      default: w_k_zero = 1'b1;
    endcase
  end

  assign w_pix_addr = c_AW'((32'(r_row) + 32'(w_row_off)) * 32'(IMG_W)
                            + 32'(r_col) + 32'(w_col_off));

  always_ff @(posedge clk) begin
    if (w_wr_ok && (bus.wr_sel == 2'd0) && (32'(bus.wr_addr) < 32'(IMG_W * IMG_W)))
      r_img[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= c_IDLE;
      r_tap   <= '0;
      r_kr    <= '0;
      r_kc    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_pixel <= '0;
    end else begin
      r_pixel <= w_pix_zero ? 16'sd0 : r_img[w_pix_addr];
      case (r_state)
        c_IDLE: begin
          if (bus.go) r_state <= c_PRIME;
        end
        c_PRIME: begin
          r_state <= c_STREAM;
          r_tap   <= '0;
          r_kr    <= '0;
          r_kc    <= '0;
        end
        c_STREAM: begin
          if (w_last_tap) begin
            r_state <= c_WAIT;
          end else begin
            r_tap <= r_tap + 1'b1;
            r_kr  <= w_nkr;
            r_kc  <= w_nkc;
          end
        end
        c_WAIT: begin
          if (bus.conv_ready) begin
            if (w_last_win) begin
              r_state <= c_DONE;
            end else begin
              r_state <= c_PRIME;
              if (r_col == c_WLAST) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
          r_row   <= '0;
          r_col   <= '0;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  for (genvar ch = 1; ch <= NCH; ch++) begin : g_ch
    logic signed [15:0] r_kmem [2**c_KW];
    logic signed [15:0] r_weight;

    always_ff @(posedge clk) begin
      if (w_wr_ok && (bus.wr_sel == 2'(ch)) && (32'(bus.wr_addr) < 32'(c_NT)))
        r_kmem[bus.wr_addr[c_KW-1:0]] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) r_weight <= '0;
      else          r_weight <= w_k_zero ? 16'sd0 : r_kmem[w_k_idx];
    end

    assign bus.weight_out[ch] = r_weight;
  end : g_ch

  assign bus.pixel_out = r_pixel;
  assign bus.busy      = (r_state != c_IDLE);
  assign bus.done      = (r_state == c_DONE);
  assign bus.ready_in  = (r_state == c_STREAM);
  assign bus.start     = (r_state == c_STREAM) && (r_tap == '0);
  assign bus.win_row   = r_row;
  assign bus.win_col   = r_col;
endmodule
`default_nettype wire

// File: tb/tb_conv_window_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_conv_window_feeder
// Brief   : Directed bench: 6x6 image, 5x5 kernel, four windows per pass.
// Rev     : 1.0
// ============================================================================
module tb_conv_window_feeder;
    localparam int IMG_W = 6;
    localparam int K     = 5;
    localparam int NT    = K * K;

    logic clk     = 1'b0;
    logic n_reset = 1'b1;
    always #5 clk = ~clk;

    conv_window_feeder_if bus ();

    conv_window_feeder #(.IMG_W(IMG_W), .K(K), .NCH(3)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [15:0] m_img [IMG_W*IMG_W];
    logic signed [15:0] m_k   [1:3][NT];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input int addr, input logic signed [15:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = 10'(addr);
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // action: 0 none, 1 writes while busy, 2 go during STREAM, 3 reset at tap 10 of window (0,1)
    task automatic run_pass(input int rdy_mode, input int action);
        int er, ec, idx;
        logic signed [15:0] ew;
        bus.go = 1'b1;
        bus.conv_ready = (rdy_mode == 1);
        tick();
        bus.go = 1'b0;
        for (int w = 0; w < 4; w++) begin
            er = w / 2;
            ec = w % 2;
            n_tests++;
            if ({bus.busy, bus.ready_in, bus.start, bus.done} !== 4'b1000) begin
                n_fail++;
                $display("FAIL prime_ctrl w%0d: got %b want 1000", w, {bus.busy, bus.ready_in, bus.start, bus.done});
            end
            n_tests++;
            if (bus.win_row !== 8'(er) || bus.win_col !== 8'(ec)) begin
                n_fail++;
                $display("FAIL prime_pos w%0d: got (%0d,%0d) want (%0d,%0d)", w, bus.win_row, bus.win_col, er, ec);
            end
            for (int ch = 1; ch <= 3; ch++) begin
                n_tests++;
                if (bus.weight_out[ch] !== m_k[ch][0]) begin
                    n_fail++;
                    $display("FAIL prime_weight w%0d ch%0d: got %0d want %0d", w, ch, bus.weight_out[ch], m_k[ch][0]);
                end
            end
            tick();
            for (int t = 0; t < NT; t++) begin
                n_tests++;
                if ({bus.busy, bus.ready_in, bus.start, bus.done} !== {1'b1, 1'b1, (t == 0), 1'b0}) begin
                    n_fail++;
                    $display("FAIL stream_ctrl w%0d t%0d: got %b want 11%0d0", w, t, {bus.busy, bus.ready_in, bus.start, bus.done}, (t == 0));
                end
                idx = (er + t / K) * IMG_W + ec + t % K;
                n_tests++;
                if (bus.pixel_out !== m_img[idx]) begin
                    n_fail++;
                    $display("FAIL stream_pixel w%0d t%0d: got %0d want %0d", w, t, bus.pixel_out, m_img[idx]);
                end
                n_tests++;
                if (bus.win_row !== 8'(er) || bus.win_col !== 8'(ec)) begin
                    n_fail++;
                    $display("FAIL stream_pos w%0d t%0d: got (%0d,%0d) want (%0d,%0d)", w, t, bus.win_row, bus.win_col, er, ec);
                end
                for (int ch = 1; ch <= 3; ch++) begin
                    if (t < NT - 1) ew = m_k[ch][t+1];
                    else            ew = 16'sd0;
                    n_tests++;
                    if (bus.weight_out[ch] !== ew) begin
                        n_fail++;
                        $display("FAIL stream_weight w%0d t%0d ch%0d: got %0d want %0d", w, t, ch, bus.weight_out[ch], ew);
                    end
                end
                if (action == 3 && w == 1 && t == 10) begin
                    n_reset = 1'b0;
                    #1;
                    n_tests++;
                    if ({bus.pixel_out, bus.weight_out[1], bus.weight_out[2], bus.weight_out[3]} !== 64'd0) begin
                        n_fail++;
                        $display("FAIL abort_data: got pix %0d w %0d/%0d/%0d want 0", bus.pixel_out, bus.weight_out[1], bus.weight_out[2], bus.weight_out[3]);
                    end
                    n_tests++;
                    if ({bus.start, bus.ready_in, bus.busy, bus.done, bus.win_row, bus.win_col} !== 20'd0) begin
                        n_fail++;
                        $display("FAIL abort_ctrl: got %h want 0", {bus.start, bus.ready_in, bus.busy, bus.done, bus.win_row, bus.win_col});
                    end
                    repeat (4) begin
                        tick();
                        n_tests++;
                        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                            n_fail++;
                            $display("FAIL abort_no_done: got done=%b busy=%b want 0 0", bus.done, bus.busy);
                        end
                    end
                    n_reset = 1'b1;
                    bus.conv_ready = 1'b0;
                    tick();
                    return;
                end
                if (action == 1 && w == 0 && t == 5) begin
                    bus.wr_en = 1'b1; bus.wr_sel = 2'd0; bus.wr_addr = 10'd0; bus.wr_data = 16'sh7FFF;
                end
                if (action == 1 && w == 0 && t == 6) begin
                    bus.wr_en = 1'b1; bus.wr_sel = 2'd2; bus.wr_addr = 10'd3; bus.wr_data = 16'sd555;
                end
                if (action == 2 && w == 0 && t == 3) bus.go = 1'b1;
                tick();
                bus.wr_en = 1'b0;
                bus.go    = 1'b0;
            end
            n_tests++;
            if ({bus.busy, bus.ready_in, bus.start, bus.done} !== 4'b1000 || bus.pixel_out !== 16'sd0) begin
                n_fail++;
                $display("FAIL wait_ctrl w%0d: got ctrl %b pix %0d want 1000 0", w, {bus.busy, bus.ready_in, bus.start, bus.done}, bus.pixel_out);
            end
            if (rdy_mode == 0) begin
                repeat (3) begin
                    tick();
                    n_tests++;
                    if (bus.ready_in !== 1'b0 || bus.win_row !== 8'(er) || bus.win_col !== 8'(ec)) begin
                        n_fail++;
                        $display("FAIL wait_hold w%0d: got ready=%b pos (%0d,%0d) want 0 (%0d,%0d)", w, bus.ready_in, bus.win_row, bus.win_col, er, ec);
                    end
                end
                bus.conv_ready = 1'b1;
                tick();
                bus.conv_ready = 1'b0;
            end else begin
                tick();
            end
        end
        n_tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b busy=%b want 1 1", bus.done, bus.busy);
        end
        tick();
        n_tests++;
        if ({bus.done, bus.busy, bus.win_row, bus.win_col} !== 18'd0) begin
            n_fail++;
            $display("FAIL after_done: got %h want 0", {bus.done, bus.busy, bus.win_row, bus.win_col});
        end
        bus.conv_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 n_reset = 1'b0;
        bus.go = 1'b1;
        repeat (2) tick();
        bus.go = 1'b0;
        n_tests++;
        if ({bus.pixel_out, bus.weight_out[1], bus.weight_out[2], bus.weight_out[3]} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_data: got pix %0d w %0d/%0d/%0d want 0", bus.pixel_out, bus.weight_out[1], bus.weight_out[2], bus.weight_out[3]);
        end
        n_tests++;
        if ({bus.start, bus.ready_in, bus.busy, bus.done, bus.win_row, bus.win_col} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h want 0", {bus.start, bus.ready_in, bus.busy, bus.done, bus.win_row, bus.win_col});
        end
        n_reset = 1'b1;
        repeat (2) tick();
        n_tests++;
        if ({bus.busy, bus.done, bus.ready_in} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b want 000", {bus.busy, bus.done, bus.ready_in});
        end
    endtask

    task automatic load_defaults();
        for (int i = 0; i < IMG_W * IMG_W; i++) begin
            wr(2'd0, i, 16'(i));
            m_img[i] = 16'(i);
        end
        for (int ch = 1; ch <= 3; ch++)
            for (int t = 0; t < NT; t++) begin
                wr(2'(ch), t, 16'sd1);
                m_k[ch][t] = 16'sd1;
            end
    endtask

    task automatic test_basic_pass();
        run_pass(0, 0);
    endtask

    // Distinct per-channel kernels; conv_ready held high through the pass.
    task automatic test_weights_held_ready();
        for (int t = 0; t < NT; t++) begin
            wr(2'd1, t, 16'(t));        m_k[1][t] = 16'(t);
            wr(2'd2, t, 16'(100 + t));  m_k[2][t] = 16'(100 + t);
            wr(2'd3, t, 16'(-t));       m_k[3][t] = 16'(-t);
        end
        run_pass(1, 0);
    endtask

    task automatic test_go_ignored();
        run_pass(0, 2);
    endtask

    task automatic test_load_guard();
        run_pass(0, 1);
        run_pass(1, 0);
        wr(2'd1, 32, 16'sd999);
        wr(2'd0, 0, 16'sh7FFF);
        m_img[0] = 16'sh7FFF;
        run_pass(1, 0);
    endtask

    task automatic test_reset_mid_pass();
        run_pass(0, 3);
        run_pass(0, 0);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_sel = 2'd0; bus.wr_addr = 10'd0; bus.wr_data = 16'sd0;
        bus.go = 1'b0; bus.conv_ready = 1'b0;
        test_reset();
        load_defaults();
        test_basic_pass();
        test_weights_held_ready();
        test_go_ignored();
        test_load_guard();
        test_reset_mid_pass();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 SHALL provide parameter IMG_W, default 28: image width and height in pixels (square image).
REQ-002 SHALL provide parameter K, default 5: kernel width and height; taps per window NT = K*K.
REQ-003 SHALL provide parameter NCH, default 3: number of output channels; fixed at 3 in this release.
REQ-004 clk  input  1  clock, rising-edge active.
REQ-005 n_reset  input  1  reset, asynchronous, active-low.
REQ-006 wr_en  input  1  load-port write strobe.
REQ-007 wr_sel  input  2  load target: 0 = image memory, 1..3 = kernel memory of channel 1..3.
REQ-008 wr_addr  input  10  load address: pixel index r*IMG_W+c, or tap index 0..NT-1.
REQ-009 wr_data  input  16 signed  load data.
REQ-010 go  input  1  single-cycle pulse that starts a full image pass.
REQ-011 conv_ready  input  1  result-valid from the downstream convolution layer.
REQ-012 pixel_out  output  16 signed  current tap pixel.
REQ-013 weight_out[3:1]  output  3x16 signed  per-channel weights, leading pixel_out by one cycle.
REQ-014 start  output  1  high on tap 0 of each window.
REQ-015 ready_in  output  1  tap valid.
REQ-016 win_row, win_col  output  8 each  position of the window currently being streamed.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse at the end of a pass.

Function
REQ-019 States SHALL be IDLE, PRIME, STREAM, WAIT, DONE.
REQ-020 IDLE: go=1 -> PRIME; win_row=win_col=0; go during any other state ignored.
REQ-021 PRIME: exactly 1 cycle; weight_out[ch] = kernel_ch[0]; ready_in=0, start=0; -> STREAM with tap t=0.
REQ-022 STREAM: NT consecutive cycles, t=0..NT-1; ready_in=1; start=(t==0).
REQ-023 STREAM pixel_out = image[(win_row+t/K)*IMG_W + win_col + t%K]; taps are row-major within the window.
REQ-024 STREAM weight_out[ch] = kernel_ch[t+1] for t<NT-1, and 0 at t=NT-1.
REQ-025 After tap NT-1 -> WAIT; WAIT drives ready_in=0, start=0, pixel_out=0.
REQ-026 WAIT + conv_ready=1, last window (win_row=win_col=IMG_W-K) -> DONE.
REQ-027 WAIT + conv_ready=1, other window -> advance the window and -> PRIME.
REQ-028 Window advance: win_col+1; at IMG_W-K, wrap to 0 and win_row+1.
REQ-029 conv_ready outside WAIT SHALL be ignored; conv_ready held high SHALL advance exactly one window per WAIT entry.
REQ-030 DONE: done=1 for 1 cycle -> IDLE; total windows per pass = (IMG_W-K+1)^2.
REQ-031 Load port SHALL write only when busy=0.
REQ-032 Load writes SHALL be ignored when busy=1, or when wr_addr is out of range for the selected target.
REQ-033 Memories SHALL NOT be cleared by reset; contents persist across passes.
REQ-034 Memory reads SHALL be registered so outputs meet the cycle alignment of REQ-021..024.
REQ-035 Address arithmetic SHALL be unsigned, at least 10 bits; pixel and weight data SHALL pass through unmodified.

Reset
REQ-036 n_reset=0 SHALL asynchronously force state IDLE.
REQ-037 n_reset=0 SHALL clear pixel_out, weight_out, start, ready_in, busy, done, win_row, win_col, and the tap counter to 0.
REQ-038 Reset mid-pass SHALL abort the pass with no done pulse; the first go after reset restarts at window (0,0).

Verification
REQ-039 IMG_W=6, K=5, image[i]=i, kernels all 1; go; conv_ready 1-cycle pulse 3 cycles after each WAIT entry -> 4 windows in order (0,0),(0,1),(1,0),(1,1); window (1,1) taps = 7,8,9,10,11,13..17,19..23,25..29,31..35; one done pulse.
REQ-040 Kernel ch1[t]=t, ch2[t]=100+t, ch3[t]=-t -> weight_out=(0,100,0) in PRIME; (t+1,101+t,-(t+1)) during STREAM tap t.
REQ-041 conv_ready held at 1 for the whole pass -> each window is still preceded by PRIME plus 25 STREAM cycles; pass length = 4*(1+25+1)+1 cycles after go.
REQ-042 Write wr_sel=0, addr=0, data=16'h7FFF while busy=1 -> no effect; the same write after done -> next pass tap 0 of window (0,0) = 32767.
REQ-043 Assert n_reset=0 during tap 10 of window (0,1) -> all outputs 0 immediately, no done pulse; next go restarts at (0,0) with correct taps.
REQ-044 go asserted during STREAM -> ignored; the pass completes unchanged.
